// File: rtl/key_event_in.sv
// Pushbutton conditioner: synchronises and debounces active-low keys, then latches
// sticky press events plus an overrun flag for the core to read and acknowledge.
module key_event_in #(
  parameter int NKEYS     = 4,
  parameter int DB_CYCLES = 16,
  parameter int CW        = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [NKEYS-1:0] KEY_L,
  input  logic             RD_ACK,
  output logic [NKEYS-1:0] LEVEL,
  output logic [NKEYS-1:0] EVENT,
  output logic             OVERRUN,
  output logic             IRQ,
  output logic [7:0]       IO_OUT
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Zero-extend a per-key vector into one nibble of the port byte.
  function automatic logic [3:0] pad4(input logic [NKEYS-1:0] v);
    logic [3:0] r;
    r = '0;
    r[NKEYS-1:0] = v;
    return r;
  endfunction

  logic [NKEYS-1:0] sync_p0;
  logic [NKEYS-1:0] sync_p1;
  logic [NKEYS-1:0] pressed_p1;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];
  logic [NKEYS-1:0] level_d;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] event_d;
  logic             overrun_d;

  // Stage p0/p1: two-flop synchroniser; reset value 1 means "released".
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= KEY_L;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_p1 = ~sync_p1;

  // Stage p2: debounce; LEVEL flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = LEVEL;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = '0;
      if (pressed_p1[i] != LEVEL[i]) begin
        if (cnt_q[i] >= CNT_MAX) begin
          level_d[i] = pressed_p1[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_d & ~LEVEL;

  always_comb begin
    event_d = RD_ACK ? '0 : EVENT;
    event_d = event_d | press;
    if (|(press & EVENT) && !RD_ACK) begin
      overrun_d = 1'b1;
    end else if (RD_ACK) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = OVERRUN;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
      LEVEL   <= '0;
      EVENT   <= '0;
      OVERRUN <= 1'b0;
      IRQ     <= 1'b0;
      IO_OUT  <= 8'h00;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      LEVEL   <= level_d;
      EVENT   <= event_d;
      OVERRUN <= overrun_d;
      // Built from next-state values so the port byte tracks EVENT/LEVEL without lag.
      IRQ     <= |event_d;
      IO_OUT  <= {pad4(event_d), pad4(level_d)};
    end
  end

endmodule
